alarm_buzzer_cntr: RTL and testbench
====================================

ALARM_BUZZER_CNTR -- requirements
Module: alarm_buzzer_cntr

Interface
REQ-001 Parameter SYS_FREQ, default 100_000_000: clk frequency in Hz.
REQ-002 Parameter TONE_FREQ, default 2000: buzzer tone frequency in Hz.
REQ-003 Parameter ON_MS, default 200: beep-on length in ms.
REQ-004 Parameter OFF_MS, default 200: gap length between beeps in ms.
REQ-005 Parameter TIMEOUT_MS, default 30000: maximum total beeping time per alarm, in ms.
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 reset_p  input  1  asynchronous, active-high reset.
REQ-008 alarm  input  1  level alarm request from cook_timer; synchronous to clk.
REQ-009 silence  input  1  one-cycle pulse from button_cntr btn_pedge; mutes the current alarm.
REQ-010 buz  output  1  registered square-wave drive for the piezo buzzer.
REQ-011 beeping  output  1  high while the pattern is active (ON or OFF state); drives an LED.

Function
REQ-012 HALF = SYS_FREQ/(2*TONE_FREQ) and MS_DIV = SYS_FREQ/1000, integer division; every counter width SHALL be $clog2 of its terminal value plus 1.
REQ-013 The state machine SHALL use four states: IDLE, ON, OFF, HOLD.
REQ-014 In IDLE with alarm=1, the next edge SHALL enter ON, set buz=1, and clear the tone, ms-prescaler, phase and timeout counters.
REQ-015 In ON, buz SHALL toggle every HALF clocks; the first toggle comes HALF clocks after entry.
REQ-016 A 1 ms tick SHALL pulse once every MS_DIV clocks while in ON or OFF, and stays idle in IDLE and HOLD.
REQ-017 After ON_MS ticks in ON, the machine SHALL enter OFF with buz=0; after OFF_MS ticks in OFF, it SHALL re-enter ON with buz=1 and the tone counter cleared.
REQ-018 The timeout counter SHALL count ticks in both ON and OFF; on reaching TIMEOUT_MS, the next edge SHALL enter HOLD.
REQ-019 silence=1 in ON or OFF SHALL enter HOLD on the next edge.
REQ-020 In HOLD, buz SHALL be 0; alarm=0 SHALL return the machine to IDLE, and a new alarm rising edge is required to beep again.
REQ-021 alarm=0 in ON, OFF or HOLD SHALL enter IDLE on the next edge and force buz=0.
REQ-022 Priority when events coincide: alarm=0 > silence > timeout > phase expiry.
REQ-023 silence in IDLE or HOLD SHALL be ignored.
REQ-024 buz SHALL be 0 in every state except ON.
REQ-025 beeping SHALL be registered, equal to (state==ON || state==OFF), and change on the same edge as the state.

Reset
REQ-026 reset_p=1 SHALL immediately force state=IDLE, buz=0, beeping=0 and every counter to 0, regardless of clk.
REQ-027 If reset is asserted mid-beep and then released with alarm still high, the next edge SHALL enter ON as a fresh alarm.

Structure
REQ-028 The state encodings and the default timing constants SHALL live in the shared timer package, so that cook_timer and top-level modules can reference them.
REQ-029 The 1 ms prescaler SHALL be a separate sub-module, tick_gen (parameter DIV; ports clk, reset_p, en, tick), reusable by the watch and cook-timer modules.
REQ-030 In mutifunction_watch_top, the block SHALL replace the direct buz=alarm connection and take silence from btn_pedge of a dedicated button.

Verification (SYS_FREQ=10_000, TONE_FREQ=1000, ON_MS=2, OFF_MS=2, TIMEOUT_MS=10, so HALF=5 and MS_DIV=10)
REQ-031 alarm rises at cycle 0 -> buz=1 and beeping=1 at cycle 1; buz toggles at cycles 6, 11, 16; buz=0 from cycle 21 to 40; buz=1 again at cycle 41.
REQ-032 alarm held high -> HOLD at cycle 101 (10 ms); buz=0 and beeping=0 from then on, until alarm drops and rises again.
REQ-033 silence pulse at cycle 8 -> HOLD at cycle 9 with buz=0; a further silence has no effect; alarm=0 -> IDLE on the next edge.
REQ-034 alarm=0 and silence=1 in the same cycle -> IDLE (not HOLD) on the next edge; a subsequent alarm=1 beeps immediately.
REQ-035 reset_p pulsed at cycle 13 with alarm high -> buz=0 and beeping=0 asynchronously; after release, ON on the first edge, with the tone phase restarted.

Source files
------------

// File: rtl/alarm_buzzer_cntr_pkg.sv
// Shared timer package: buzzer state encoding, default timing constants
// and the counter width helper.
package alarm_buzzer_cntr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    HOLD = 2'd3
  } buz_state_t;

  localparam int DEF_SYS_FREQ   = 100_000_000;
  localparam int DEF_TONE_FREQ  = 2000;
  localparam int DEF_ON_MS      = 200;
  localparam int DEF_OFF_MS     = 200;
  localparam int DEF_TIMEOUT_MS = 30000;

  // Counter width for a counter whose terminal value is term.
  function automatic int cnt_w(input int term);
    return $clog2(term) + 1;
  endfunction

endpackage

// File: rtl/alarm_buzzer_cntr_tick_gen.sv
// Enable-gated prescaler: one-cycle tick every DIV clocks while en is high.
// Dropping en clears the count, so the next enable starts a fresh period.
module tick_gen
  import alarm_buzzer_cntr_pkg::*;
#(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic en,
  output logic tick
);

  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Free-run while enabled, wrap on tick, hold at zero while disabled.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)           cnt <= '0;
    else if (!en || tick)  cnt <= '0;
    else                   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/alarm_buzzer_cntr.sv
// Alarm buzzer: beeps a square tone in ON/OFF bursts while alarm is high,
// until silenced, timed out, or the alarm is withdrawn.
module alarm_buzzer_cntr
  import alarm_buzzer_cntr_pkg::*;
#(
  parameter int SYS_FREQ   = DEF_SYS_FREQ,
  parameter int TONE_FREQ  = DEF_TONE_FREQ,
  parameter int ON_MS      = DEF_ON_MS,
  parameter int OFF_MS     = DEF_OFF_MS,
  parameter int TIMEOUT_MS = DEF_TIMEOUT_MS
) (
  input  logic clk,
  input  logic reset_p,
  input  logic alarm,
  input  logic silence,
  output logic buz,
  output logic beeping
);

  localparam int HALF   = SYS_FREQ / (2 * TONE_FREQ);
  localparam int MS_DIV = SYS_FREQ / 1000;
  localparam int PH_MAX = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int TW     = cnt_w(HALF);
  localparam int PW     = cnt_w(PH_MAX);
  localparam int OW     = cnt_w(TIMEOUT_MS);

  localparam logic [TW-1:0] TONE_LAST = TW'(HALF - 1);
  localparam logic [PW-1:0] ON_LAST   = PW'(ON_MS - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_MS - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT_MS - 1);

  buz_state_t state, nxt;
  logic [TW-1:0] tone;
  logic [PW-1:0] phase;
  logic [OW-1:0] to_cnt;
  logic          active, tick, timeout, phase_done, stay_active;

  assign active      = (state == ON) || (state == OFF);
  assign timeout     = tick && (to_cnt == TO_LAST);
  assign phase_done  = tick && (phase == ((state == ON) ? ON_LAST : OFF_LAST));
  assign stay_active = (nxt == ON) || (nxt == OFF);

  // Millisecond prescaler only runs while the pattern is active.
  tick_gen #(.DIV(MS_DIV)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .en      (active),
    .tick    (tick)
  );

  // Next-state: alarm drop beats silence beats timeout beats phase expiry.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (alarm) nxt = ON;
      ON, OFF: begin
        if (!alarm)          nxt = IDLE;
        else if (silence)    nxt = HOLD;
        else if (timeout)    nxt = HOLD;
        else if (phase_done) nxt = (state == ON) ? OFF : ON;
      end
      HOLD: if (!alarm) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register; beeping follows the state on the same edge.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state   <= IDLE;
      beeping <= 1'b0;
    end else begin
      state   <= nxt;
      beeping <= stay_active;
    end
  end

  // Tone, phase and timeout counters plus the registered buzzer drive.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      tone   <= '0;
      phase  <= '0;
      to_cnt <= '0;
      buz    <= 1'b0;
    end else begin
      // Tone restarts high on every ON entry and toggles every HALF clocks.
      if (nxt == ON && state == ON) begin
        tone <= (tone == TONE_LAST) ? '0 : tone + TW'(1);
        if (tone == TONE_LAST) buz <= ~buz;
      end else begin
        tone <= '0;
        buz  <= (nxt == ON);
      end
      // Phase counts ticks within one ON or OFF burst.
      if (active && nxt == state) phase <= tick ? phase + PW'(1) : phase;
      else                        phase <= '0;
      // Timeout spans every ON/OFF burst of one alarm.
      if (active && stay_active)  to_cnt <= tick ? to_cnt + OW'(1) : to_cnt;
      else                        to_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_alarm_buzzer_cntr.sv
// Directed bench for alarm_buzzer_cntr with HALF=5, MS_DIV=10.
module tb_alarm_buzzer_cntr;

  logic clk = 1'b0;
  logic reset_p, alarm, silence;
  logic buz, beeping;
  int   n_chk = 0;
  int   n_fail = 0;

  alarm_buzzer_cntr #(
    .SYS_FREQ   (10_000),
    .TONE_FREQ  (1000),
    .ON_MS      (2),
    .OFF_MS     (2),
    .TIMEOUT_MS (10)
  ) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .alarm   (alarm),
    .silence (silence),
    .buz     (buz),
    .beeping (beeping)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2 time units later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    alarm   = 1'b0;
    silence = 1'b0;
    step();
    step();
    reset_p = 1'b0;
    step();
  endtask

  initial begin
    reset_p = 1'b1;
    alarm   = 1'b0;
    silence = 1'b0;
    step();
    chk("rst_buz", buz, 1'b0);
    chk("rst_beeping", beeping, 1'b0);

    // Basic pattern and timeout into HOLD.
    do_reset();
    alarm = 1'b1;                              // cycle 0
    for (int c = 1; c <= 41; c++) begin
      logic e;
      step();
      if (c <= 20)      e = (((c - 1) / 5) % 2) == 0;
      else if (c <= 40) e = 1'b0;
      else              e = 1'b1;
      chk($sformatf("pat_buz_c%0d", c), buz, e);
      chk($sformatf("pat_beep_c%0d", c), beeping, 1'b1);
    end
    for (int c = 42; c <= 100; c++) step();
    chk("to_beep_c100", beeping, 1'b1);
    step();                                    // cycle 101
    chk("to_beep_c101", beeping, 1'b0);
    chk("to_buz_c101", buz, 1'b0);
    for (int c = 102; c <= 121; c++) step();
    chk("hold_beep_c121", beeping, 1'b0);
    chk("hold_buz_c121", buz, 1'b0);
    alarm = 1'b0;
    step();
    chk("hold_idle_beep", beeping, 1'b0);
    alarm = 1'b1;
    step();
    chk("rearm_beep", beeping, 1'b1);
    chk("rearm_buz", buz, 1'b1);

    // Silence mutes, repeated silence ignored, alarm drop returns to IDLE.
    do_reset();
    alarm = 1'b1;
    for (int c = 1; c <= 8; c++) step();
    chk("sil_beep_c8", beeping, 1'b1);
    silence = 1'b1;
    step();                                    // cycle 9
    silence = 1'b0;
    chk("sil_beep_c9", beeping, 1'b0);
    chk("sil_buz_c9", buz, 1'b0);
    step();
    step();
    silence = 1'b1;
    step();
    silence = 1'b0;
    step();
    chk("sil2_beep", beeping, 1'b0);
    chk("sil2_buz", buz, 1'b0);
    alarm = 1'b0;
    step();
    chk("sil_idle_beep", beeping, 1'b0);
    alarm = 1'b1;
    step();
    chk("sil_rearm_beep", beeping, 1'b1);
    chk("sil_rearm_buz", buz, 1'b1);

    // Alarm drop wins over a coincident silence.
    do_reset();
    alarm = 1'b1;
    for (int c = 1; c <= 5; c++) step();
    alarm   = 1'b0;
    silence = 1'b1;
    step();
    silence = 1'b0;
    chk("prio_beep", beeping, 1'b0);
    chk("prio_buz", buz, 1'b0);
    alarm = 1'b1;
    step();
    chk("prio_rearm_beep", beeping, 1'b1);
    chk("prio_rearm_buz", buz, 1'b1);

    // Asynchronous reset mid-beep, then a fresh alarm with tone restarted.
    do_reset();
    alarm = 1'b1;
    for (int c = 1; c <= 13; c++) step();
    chk("ar_buz_c13", buz, 1'b1);
    reset_p = 1'b1;
    #1;
    chk("ar_async_buz", buz, 1'b0);
    chk("ar_async_beep", beeping, 1'b0);
    step();
    reset_p = 1'b0;
    step();                                    // entry into ON
    chk("ar_entry_buz", buz, 1'b1);
    chk("ar_entry_beep", beeping, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("ar_e4_buz", buz, 1'b1);
    step();
    chk("ar_e5_buz", buz, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
